// File: rtl/sanduiche_pkg.sv
// rtl/sanduiche_pkg.sv - shared encodings, prices and state type for the sandwich client
package sanduiche_pkg;

  localparam int TIMEOUT_DEFAULT = 63;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_GREEN = 2'b01;
  localparam logic [1:0] SEL_ATUM  = 2'b10;
  localparam logic [1:0] SEL_BACON = 2'b11;

  localparam logic [2:0] PRICE_GREEN = 3'd2;
  localparam logic [2:0] PRICE_ATUM  = 3'd3;
  localparam logic [2:0] PRICE_BACON = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    COIN,
    GAP,
    REQ,
    WAIT_P,
    FIN
  } state_e;

  // Price in coins of a product code; the refund-only code costs nothing.
  function automatic logic [2:0] price_of(input logic [1:0] sel);
    logic [2:0] p;
    case (sel)
      SEL_GREEN: p = PRICE_GREEN;
      SEL_ATUM:  p = PRICE_ATUM;
      SEL_BACON: p = PRICE_BACON;
      default:   p = 3'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sanduiche_cliente_sat_cnt3.sv
// rtl/sanduiche_cliente_sat_cnt3.sv - 3-bit counter that sticks at 7 instead of wrapping
module sat_cnt3 (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] q
);

  logic [2:0] q_q;
  logic [2:0] q_d;

  // Clear wins over increment; increment stops at the top value.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 3'd0;
    end else if (inc && (q_q != 3'd7)) begin
      q_d = q_q + 3'd1;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= 3'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sanduiche_cliente.sv
// rtl/sanduiche_cliente.sv - host-side client that pays, orders and collects from a sandwich machine
module sanduiche_cliente
  import sanduiche_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [2:0] coins,
  output logic       ready,
  output logic       done,
  output logic [1:0] product,
  output logic [2:0] change,
  output logic       timeout,
  output logic       proto_err,
  output logic       M100,
  output logic       R_green,
  output logic       R_atum,
  output logic       R_bacon,
  output logic       DEV,
  input  logic       busy,
  input  logic       erro,
  input  logic       GREEN,
  input  logic       ATUM,
  input  logic       BACON,
  input  logic       D100
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            seen_busy_q, seen_busy_d;
  logic            seen_prod_q, seen_prod_d;
  logic [1:0]      product_q, product_d;
  logic            timeout_q, timeout_d;
  logic            perr_q, perr_d;
  logic            chg_inc;
  logic            chg_clr;
  logic [1:0]      pulse_n;
  logic [1:0]      pulse_code;

  // Decode the product lines: how many fired this cycle and which code the highest one means.
  always_comb begin
    pulse_n    = {1'b0, GREEN} + {1'b0, ATUM} + {1'b0, BACON};
    pulse_code = SEL_NONE;
    if (BACON) begin
      pulse_code = SEL_BACON;
    end else if (ATUM) begin
      pulse_code = SEL_ATUM;
    end else if (GREEN) begin
      pulse_code = SEL_GREEN;
    end
  end

  // Order sequencer: next state, machine strobes and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    seen_prod_d = seen_prod_q;
    product_d   = product_q;
    timeout_d   = timeout_q;
    perr_d      = perr_q;
    chg_inc     = 1'b0;
    chg_clr     = 1'b0;
    M100        = 1'b0;
    R_green     = 1'b0;
    R_atum      = 1'b0;
    R_bacon     = 1'b0;
    DEV         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d     = sel;
          rem_d     = coins;
          product_d = SEL_NONE;
          timeout_d = 1'b0;
          perr_d    = 1'b0;
          chg_clr   = 1'b1;
          state_d   = COIN;
        end
      end
      COIN: begin
        if (rem_q == 3'd0) begin
          state_d = REQ;
        end else if (!busy) begin
          M100    = 1'b1;
          rem_d   = rem_q - 3'd1;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = COIN;
      end
      REQ: begin
        if (!busy) begin
          case (sel_q)
            SEL_GREEN: R_green = 1'b1;
            SEL_ATUM:  R_atum  = 1'b1;
            SEL_BACON: R_bacon = 1'b1;
            default:   DEV     = 1'b1;
          endcase
          cnt_d       = '0;
          seen_busy_d = 1'b0;
          seen_prod_d = 1'b0;
          state_d     = WAIT_P;
        end
      end
      WAIT_P: begin
        chg_inc = D100;
        if (busy) begin
          seen_busy_d = 1'b1;
        end
        if (erro) begin
          perr_d = 1'b1;
        end
        if (pulse_n != 2'd0) begin
          // Only the first delivery counts; repeats or a wrong code are protocol errors.
          if (seen_prod_q || (pulse_n > 2'd1) || (pulse_code != sel_q)) begin
            perr_d = 1'b1;
          end
          if (!seen_prod_q) begin
            product_d = pulse_code;
          end
          seen_prod_d = 1'b1;
        end
        // The machine finished once it has been busy and then dropped busy again.
        if (seen_busy_q && !busy) begin
          state_d = FIN;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and order registers; reset returns to idle with every result cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= SEL_NONE;
      rem_q       <= 3'd0;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      seen_prod_q <= 1'b0;
      product_q   <= SEL_NONE;
      timeout_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      seen_prod_q <= seen_prod_d;
      product_q   <= product_d;
      timeout_q   <= timeout_d;
      perr_q      <= perr_d;
    end
  end

  sat_cnt3 u_change (
    .clock (clock),
    .reset (reset),
    .inc   (chg_inc),
    .clr   (chg_clr),
    .q     (change)
  );

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == FIN);
  assign product   = product_q;
  assign timeout   = timeout_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_sanduiche_cliente.sv
// tb/tb_sanduiche_cliente.sv - randomized self-checking bench with a behavioural vending-machine model
module tb_sanduiche_cliente;
  import sanduiche_pkg::*;

  localparam int TMO = 63;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] sel;
  logic [2:0] coins;
  logic       ready;
  logic       done;
  logic [1:0] product;
  logic [2:0] change;
  logic       timeout;
  logic       proto_err;
  logic       M100, R_green, R_atum, R_bacon, DEV;
  logic       busy, erro, GREEN, ATUM, BACON, D100;

  int n_checks = 0;
  int n_errors = 0;

  sanduiche_cliente #(.TIMEOUT(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .sel       (sel),
    .coins     (coins),
    .ready     (ready),
    .done      (done),
    .product   (product),
    .change    (change),
    .timeout   (timeout),
    .proto_err (proto_err),
    .M100      (M100),
    .R_green   (R_green),
    .R_atum    (R_atum),
    .R_bacon   (R_bacon),
    .DEV       (DEV),
    .busy      (busy),
    .erro      (erro),
    .GREEN     (GREEN),
    .ATUM      (ATUM),
    .BACON     (BACON),
    .D100      (D100)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_machine();
    busy  = 1'b0;
    erro  = 1'b0;
    GREEN = 1'b0;
    ATUM  = 1'b0;
    BACON = 1'b0;
    D100  = 1'b0;
  endtask

  // One complete order against a machine that sells when paid enough and refunds otherwise.
  task automatic run_order(input string tag, input logic [1:0] s, input logic [2:0] c,
                           input int stall, input bit silent, input bit wrong_prod,
                           input bit extra_prod, input bit do_erro, input int extra_d100);
    bit         buy;
    logic [1:0] deliv;
    logic [1:0] req_code;
    int nd, ntot, blen, exp_chg, exp_req, exp_lat;
    int req_cyc, m100_n, req_n, first_m100, last_m100, gap_bad, excl_bad;
    int busy_m100, ready_bad, done_cyc, stall_left, ones, t;

    buy     = (s != SEL_NONE) && (c >= price_of(s));
    deliv   = !buy ? SEL_NONE : (wrong_prod ? ((s == SEL_GREEN) ? SEL_ATUM : SEL_GREEN) : s);
    nd      = buy ? int'(c) - int'(price_of(s)) : int'(c);
    ntot    = nd + extra_d100;
    blen    = 2 + ntot;
    exp_chg = silent ? 0 : ((ntot > 7) ? 7 : ntot);
    exp_req = (c != 3'd0) ? 2 * int'(c) + 2 + stall : ((stall + 1 > 2) ? stall + 1 : 2);
    exp_lat = silent ? TMO + 2 : blen + 2;

    @(posedge clock); #1;
    start = 1'b1; sel = s; coins = c;
    idle_machine();
    @(posedge clock); #1;

    req_cyc = -1; m100_n = 0; req_n = 0; first_m100 = -1; last_m100 = -1;
    gap_bad = 0; excl_bad = 0; busy_m100 = 0; ready_bad = 0; done_cyc = -1;
    stall_left = stall; req_code = 2'b00;

    for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
      start = 1'($urandom_range(0, 1));
      sel   = 2'($urandom);
      coins = 3'($urandom);
      idle_machine();
      if (req_cyc < 0) begin
        if (stall_left > 0) begin
          busy = 1'b1;
          stall_left--;
        end
      end else if (!silent) begin
        t = k - req_cyc;
        if (t <= blen) begin
          busy = 1'b1;
          if ((t == 1 || (t == 2 && extra_prod)) && deliv != SEL_NONE) begin
            GREEN = (deliv == SEL_GREEN);
            ATUM  = (deliv == SEL_ATUM);
            BACON = (deliv == SEL_BACON);
          end
          if (t >= 2 && t - 2 < ntot) D100 = 1'b1;
          if (t == 2 && do_erro) erro = 1'b1;
        end
      end
      @(negedge clock);
      ones = int'(M100) + int'(R_green) + int'(R_atum) + int'(R_bacon) + int'(DEV);
      if (ones > 1) excl_bad++;
      if (M100) begin
        m100_n++;
        if (busy) busy_m100++;
        if (first_m100 < 0) first_m100 = k;
        else if (k - last_m100 != 2) gap_bad++;
        last_m100 = k;
      end
      if (R_green || R_atum || R_bacon || DEV) begin
        req_n++;
        req_cyc  = k;
        req_code = {R_atum | R_bacon, R_green | R_bacon};
      end
      if (done) done_cyc = k;
      else if (ready) ready_bad++;
      @(posedge clock); #1;
    end

    start = 1'b0; sel = 2'b00; coins = 3'd0;
    idle_machine();

    check_eq({tag, "/done_seen"}, 32'(done_cyc > 0), 1);
    check_eq({tag, "/m100_count"}, m100_n, int'(c));
    if (c != 3'd0) check_eq({tag, "/first_m100"}, first_m100, 1 + stall);
    check_eq({tag, "/m100_gap"}, gap_bad, 0);
    check_eq({tag, "/m100_busy"}, busy_m100, 0);
    check_eq({tag, "/exclusive"}, excl_bad, 0);
    check_eq({tag, "/req_count"}, req_n, 1);
    check_eq({tag, "/req_code"}, req_code, s);
    check_eq({tag, "/req_cycle"}, req_cyc, exp_req);
    check_eq({tag, "/done_lat"}, done_cyc - req_cyc, exp_lat);
    check_eq({tag, "/busy_ready"}, ready_bad, 0);
    check_eq({tag, "/product"}, product, silent ? 2'b00 : deliv);
    check_eq({tag, "/change"}, change, exp_chg);
    check_eq({tag, "/timeout"}, timeout, silent);
    check_eq({tag, "/proto_err"}, proto_err,
             !silent && ((buy && (wrong_prod || extra_prod)) || do_erro));

    @(negedge clock);
    check_eq({tag, "/done_pulse"}, done, 0);
    check_eq({tag, "/ready_after"}, ready, 1);
  endtask

  initial begin
    bit got;
    reset = 1'b0; start = 1'b0; sel = 2'b00; coins = 3'd0;
    idle_machine();
    #1;
    check_eq("reset/ready", ready, 1);
    check_eq("reset/outs",
             {done, M100, R_green, R_atum, R_bacon, DEV, timeout, proto_err, product, change}, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    run_order("green2",   SEL_GREEN, 3'd2, 0, 0, 0, 0, 0, 0);
    run_order("bacon6",   SEL_BACON, 3'd6, 0, 0, 0, 0, 0, 0);
    run_order("atum1",    SEL_ATUM,  3'd1, 0, 0, 0, 0, 0, 0);
    run_order("dev_tmo",  SEL_NONE,  3'd0, 0, 1, 0, 0, 0, 0);
    run_order("stall5",   SEL_GREEN, 3'd2, 5, 0, 0, 0, 0, 0);
    run_order("stall_c0", SEL_NONE,  3'd0, 4, 0, 0, 0, 0, 0);
    run_order("sat7",     SEL_NONE,  3'd7, 0, 0, 0, 0, 0, 3);
    run_order("wrongp",   SEL_ATUM,  3'd5, 0, 0, 1, 0, 0, 0);
    run_order("extrap",   SEL_BACON, 3'd4, 0, 0, 0, 1, 0, 0);
    run_order("erro",     SEL_GREEN, 3'd3, 0, 0, 0, 0, 1, 0);

    // Reset while the machine is answering: everything must drop in the same cycle.
    @(posedge clock); #1;
    start = 1'b1; sel = SEL_ATUM; coins = 3'd3;
    @(posedge clock); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (R_atum) got = 1'b1;
      else begin @(posedge clock); #1; end
    end
    check_eq("rst/req_seen", got, 1);
    @(posedge clock); #1;
    busy = 1'b1; ATUM = 1'b1; D100 = 1'b1;
    @(posedge clock); #1;
    ATUM = 1'b0;
    @(posedge clock); #1;
    check_eq("rst/pre_product", product, SEL_ATUM);
    check_eq("rst/pre_change", change, 2);
    #2 reset = 1'b0;
    #1;
    check_eq("rst/ready", ready, 1);
    check_eq("rst/outs",
             {done, M100, R_green, R_atum, R_bacon, DEV, timeout, proto_err, product, change}, 0);
    #1 reset = 1'b1;
    idle_machine();
    run_order("after_rst", SEL_BACON, 3'd5, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      run_order($sformatf("rnd%0d", i), 2'($urandom), 3'($urandom), $urandom_range(0, 4),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
